uart_rx_os: RTL and testbench

- Oversampling UART receiver (8N1, LSB first) that sits directly upstream of the seven-segment display driver.
- Converts the asynchronous serial line into a registered byte plus a one-cycle valid strobe.
- The display stage latches the byte on that strobe.
- Adds majority-vote sampling, start-bit glitch rejection and stop-bit framing-error reporting.

---
 rtl/uart_rx_os.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: majority-voted bits, start-glitch rejection,
// framing-error strobe and break recovery; registered byte plus one-cycle strobes.
module uart_rx_os #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_uart,
    output logic [7:0] uart_data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] SMP_A    = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] SMP_B    = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] SMP_C    = OW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic          rx_m_q, rx_m_d;
    logic          rx_s_q, rx_s_d;
    logic          rx_d_q, rx_d_d;
    logic [DW-1:0] div_q, div_d;
    logic [OW-1:0] os_q, os_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;

    logic tick;
    logic vote_tick;
    logic wrap;
    logic vote;

    always_comb begin
        rx_m_d = rx_uart;
        rx_s_d = rx_m_q;
        rx_d_d = rx_s_q;

        tick      = (div_q == DIV_LAST);
        vote_tick = tick && (os_q == SMP_C);
        wrap      = tick && (os_q == OS_LAST);
        // Third sample is the live synchronized line at the decision tick.
        vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

        div_d = tick ? '0 : div_q + 1'b1;
        os_d  = os_q;
        if (tick) begin
            os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        end
        smp_d = smp_q;
        if (tick && (os_q == SMP_A)) smp_d[0] = rx_s_q;
        if (tick && (os_q == SMP_B)) smp_d[1] = rx_s_q;

        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (rx_d_q && !rx_s_q) begin
                    state_d = START;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    os_d    = '0;
                end
            end
            START: begin
                if (vote_tick) begin
                    if (!vote) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            DATA: begin
                // bit_q counts bits already voted, so the start bit's own wrap is ignored.
                if (vote_tick) begin
                    shift_d = {vote, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                end
                if (wrap && (bit_q == 4'd8)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (vote_tick) begin
                    if (vote) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_m_q  <= rx_m_d;
            rx_s_q  <= rx_s_d;
            rx_d_q  <= rx_d_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_data  = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os at 16 clk/bit: table vectors, hand-written corner
// sequences and random frames checked against a byte/strobe scoreboard.
module tb_uart_rx_os;

    localparam int BIT_CLK = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_uart = 1'b1;
    logic [7:0] uart_data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_os #(
        .CLK_FREQ  (1_000_000),
        .BAUD      (62_500),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_uart   (rx_uart),
        .uart_data (uart_data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    logic        rst_at_edge = 1'b1;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: bytes expected on data_valid, count of expected frame errors,
    // and the byte the output register should currently hold.
    logic [7:0]  exp_q[$];
    int          exp_ferr = 0;
    logic [7:0]  model_data = 8'h00;
    int unsigned last_dv_cyc = 0;
    logic        prev_dv = 1'b0;
    logic        prev_fe = 1'b0;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            model_data = 8'h00;
            exp_q.delete();
            exp_ferr = 0;
            check("rst_uart_data", 32'(uart_data), 32'h00);
            check("rst_data_valid", 32'(data_valid), 32'h0);
            check("rst_frame_err", 32'(frame_err), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            prev_dv = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (data_valid) begin
                last_dv_cyc = cyc;
                check("valid_expected", 32'(data_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("rx_byte", 32'(uart_data), 32'(exp_q[0]));
                    model_data = exp_q.pop_front();
                end
            end else begin
                check("hold_data", 32'(uart_data), 32'(model_data));
            end
            if (frame_err) begin
                check("ferr_expected", 32'(frame_err), 32'(exp_ferr > 0));
                if (exp_ferr > 0) exp_ferr--;
            end
            check("strobe_exclusive", 32'(data_valid & frame_err), 32'h0);
            check("strobe_one_cycle", 32'((data_valid & prev_dv) | (frame_err & prev_fe)), 32'h0);
            prev_dv = data_valid;
            prev_fe = frame_err;
        end
    end

    task automatic send_bit(input logic v, input int goff);
        for (int k = 0; k < BIT_CLK; k++) begin
            rx_uart = (k == goff) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit,
                              input int goff, input logic [7:0] exp_d, input bit track,
                              output int unsigned t0);
        if (track) begin
            if (stop) exp_q.push_back(exp_d);
            else exp_ferr++;
        end
        t0 = cyc;
        send_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], (i == gbit) ? goff : -1);
        end
        send_bit(stop, -1);
    endtask

    task automatic idle_high(input int n);
        rx_uart = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gbit;
        int         goff;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    vec_t        tbl[6];
    int unsigned dv_at[6];
    int unsigned t0;
    int unsigned lat;
    logic        seen;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, -1, -1, 6, 8'hA5};
        tbl[1] = '{8'h3C, 1'b1, -1, -1, 0, 8'h3C};
        tbl[2] = '{8'hC3, 1'b1, -1, -1, 6, 8'hC3};
        tbl[3] = '{8'hF0, 1'b1,  3,  8, 4, 8'hF0};
        tbl[4] = '{8'h0F, 1'b1,  5, 10, 4, 8'h0F};
        tbl[5] = '{8'h00, 1'b1, -1, -1, 3, 8'h00};

        rst = 1'b1;
        rx_uart = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        idle_high(5);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gbit, tbl[i].goff,
                       tbl[i].exp_data, 1'b1, t0);
            dv_at[i] = last_dv_cyc;
            lat = last_dv_cyc - t0;
            check("latency_window", 32'(lat >= 152 && lat <= 160), 32'h1);
            check("vec_uart_data", 32'(uart_data), 32'(tbl[i].exp_data));
            check("vec_busy_idle", 32'(busy), 32'h0);
            check("vec_pending", 32'(exp_q.size()), 32'h0);
            if (i == 2) check("b2b_spacing", dv_at[2] - dv_at[1], 32'd160);
            idle_high(tbl[i].gap);
        end

        // Short low pulse: start bit rejected.
        rx_uart = 1'b0;
        repeat (4) @(negedge clk);
        rx_uart = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (busy) seen = 1'b1;
            @(negedge clk);
        end
        check("glitch_busy_seen", 32'(seen), 32'h1);
        idle_high(30);
        check("glitch_busy_clear", 32'(busy), 32'h0);
        check("glitch_data_kept", 32'(uart_data), 32'h00);

        // Bad stop bit then held-low line.
        send_frame(8'h55, 1'b0, -1, -1, 8'h00, 1'b1, t0);
        repeat (50) @(negedge clk);
        check("ferr_seen", 32'(exp_ferr), 32'h0);
        check("ferr_busy_held", 32'(busy), 32'h1);
        check("ferr_data_kept", 32'(uart_data), 32'h00);
        idle_high(4);
        check("ferr_busy_release", 32'(busy), 32'h0);
        send_frame(8'h12, 1'b1, -1, -1, 8'h12, 1'b1, t0);
        idle_high(4);
        check("after_ferr_byte", 32'(uart_data), 32'h12);

        // Reset during data bit 4, held past the end of the frame.
        fork
            send_frame(8'h81, 1'b1, -1, -1, 8'h00, 1'b0, t0);
            begin
                repeat (BIT_CLK * 5 + 8) @(negedge clk);
                rst = 1'b1;
                repeat (BIT_CLK * 5) @(negedge clk);
                rst = 1'b0;
            end
        join
        idle_high(5);
        check("post_rst_data", 32'(uart_data), 32'h00);
        send_frame(8'h81, 1'b1, -1, -1, 8'h81, 1'b1, t0);
        idle_high(3);
        check("post_rst_byte", 32'(uart_data), 32'h81);

        // Random frames: good and bad stop bits, single-clock glitches in data bits.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       stop;
            int         gbit;
            int         goff;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            gbit = int'($urandom_range(0, 7));
            goff = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1;
            send_frame(d, stop, gbit, goff, d, 1'b1, t0);
            if (stop) begin
                idle_high(int'($urandom_range(0, 6)));
            end else begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                idle_high(int'($urandom_range(2, 6)));
            end
        end
        idle_high(20);
        check("rand_pending_bytes", 32'(exp_q.size()), 32'h0);
        check("rand_pending_ferr", 32'(exp_ferr), 32'h0);
        check("rand_busy_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
